ofmap_accumulator: RTL

// - Downstream of one systolic MAC column. Captures the column's ofmap_out partial sums.
// - Accumulates them over several weight passes in a DEPTH-entry register buffer.
// - Drains the finished sums to the next stage over a valid/ready stream.
// - Lets a layer with more input channels than array rows be computed in multiple passes.
//

---
 rtl/ofmap_accumulator.sv | 102 ++++++++++
 1 files changed

// File: rtl/ofmap_accumulator.sv
// Accumulates one MAC column's partial sums over several weight passes and drains them on a valid/ready stream.
// Optional build macro OFMAP_RELU_EN clamps negative sums to zero on the drain path only.
module ofmap_accumulator #(
  parameter int OFMAP_WIDTH    = 32,
  parameter int DEPTH          = 16,
  parameter int PASS_CNT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [PASS_CNT_WIDTH-1:0]     num_passes,
  input  logic                          psum_valid,
  input  logic signed [OFMAP_WIDTH-1:0] psum_data,
  output logic                          psum_ready,
  output logic                          ofmap_valid,
  input  logic                          ofmap_ready,
  output logic signed [OFMAP_WIDTH-1:0] ofmap_data,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [AW-1:0]                 addr;
  logic [PASS_CNT_WIDTH-1:0]     pass_cnt;
  logic [PASS_CNT_WIDTH-1:0]     passes;
  logic signed [OFMAP_WIDTH-1:0] acc_mem [DEPTH];

  logic psum_fire;
  logic drain_fire;
  logic last_addr;
  logic last_pass;

  function automatic logic signed [OFMAP_WIDTH-1:0] drain_fn(
    input logic signed [OFMAP_WIDTH-1:0] x
  );
`ifdef OFMAP_RELU_EN
    return x[OFMAP_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign psum_fire  = (state == ACCUM) && psum_valid;
  assign drain_fire = (state == DRAIN) && ofmap_ready;
  assign last_addr  = (addr == AW'(DEPTH - 1));
  assign last_pass  = (pass_cnt == passes - 1'b1);

  assign psum_ready  = (state == ACCUM);
  assign ofmap_valid = (state == DRAIN);
  assign busy        = (state != IDLE);
  assign done        = drain_fire && last_addr;
  assign ofmap_data  = ofmap_valid ? drain_fn(acc_mem[addr]) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (psum_fire && last_addr && last_pass) state_nxt = DRAIN;
      DRAIN:   if (drain_fire && last_addr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      pass_cnt <= '0;
      passes   <= PASS_CNT_WIDTH'(1);
      for (int i = 0; i < DEPTH; i++) acc_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            passes   <= (num_passes == '0) ? PASS_CNT_WIDTH'(1) : num_passes;
            addr     <= '0;
            pass_cnt <= '0;
          end
        end
        ACCUM: begin
          // Pass 0 overwrites, so stale contents from the previous job never need clearing
          if (psum_fire) begin
            acc_mem[addr] <= (pass_cnt == '0) ? psum_data : acc_mem[addr] + psum_data;
            addr          <= addr + 1'b1;
            if (last_addr) pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_fire) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
